// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - shared types and constants for the multiplier arbiter
// Contents: arb_state_t FSM encoding, default operand width, requester-id width helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int rr_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - request, response and multiplier channels of mult_arbiter
// Signals: req_valid/req_ready/req_a/req_b (per-requester, packed i*WIDTH),
// rsp_valid/rsp_ready/rsp_id/rsp_product/rsp_err, mul_start/mul_a/mul_b/mul_done/mul_product.
// Modports: slave = arbiter view, master = clients plus multiplier view.
interface mult_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) ();
   import mult_pkg::*;

   localparam int IDW = rr_id_w(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_product;
   logic                  rsp_err;
   logic                  mul_start;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic                  mul_done;
   logic [2*WIDTH-1:0]    mul_product;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
      output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
      input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_a, mul_b
   );

endinterface

// File: rtl/mult_rr_picker.sv
// rtl/mult_rr_picker.sv - combinational round-robin winner selection
// Ports: req (request vector), ptr (last served index), grant_valid, grant_idx
// (first requesting index after ptr, wrapping at NREQ).
module mult_rr_picker
   import mult_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = rr_id_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            grant_valid,
   output logic [IDW-1:0]  grant_idx
);

   logic [IDW-1:0] idx;

   // Walk the ring starting just after ptr; the first hit wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = ptr;
      for (int k = 0; k < NREQ; k++) begin
         idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one multiplier among NREQ requesters
// Ports: clk, reset (asynchronous, active-high), bus (mult_arbiter_if.slave carrying the
// request, response and multiplier channels).
// Optional watchdog on mul_done enabled by macro MULT_ARB_TIMEOUT_EN.
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int TIMEOUT = 20
) (
   input logic           clk,
   input logic           reset,
   mult_arbiter_if.slave bus
);

   localparam int IDW = rr_id_w(NREQ);

   arb_state_t         state_q, state_d;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     id_q;
   logic [IDW-1:0]     grant_idx;
   logic               grant_valid;
   logic               load_req;
   logic               load_rsp;
   logic               timed_out;
   logic [NREQ-1:0]    ready_raw;
   logic [WIDTH-1:0]   op_a_q, op_b_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   a_arr [NREQ];
   logic [WIDTH-1:0]   b_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = bus.req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = bus.req_b[g*WIDTH +: WIDTH];
   end

   mult_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
      .req         (bus.req_valid),
      .ptr         (ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d       = state_q;
      load_req      = 1'b0;
      load_rsp      = 1'b0;
      ready_raw     = '0;
      bus.mul_start = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               ready_raw[grant_idx] = 1'b1;
               load_req             = 1'b1;
               state_d              = LAUNCH;
            end
         end
         LAUNCH: begin
            bus.mul_start = 1'b1;
            state_d       = WAIT;
         end
         WAIT: begin
            if (bus.mul_done || timed_out) begin
               load_rsp = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grants are suppressed while reset is held so every output reads zero.
   assign bus.req_ready = reset ? '0 : ready_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NREQ - 1);
         id_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_req) begin
            id_q   <= grant_idx;
            op_a_q <= a_arr[grant_idx];
            op_b_q <= b_arr[grant_idx];
         end
         if (load_rsp) begin
            prod_q <= timed_out ? '0 : bus.mul_product;
         end
         // The requester just served becomes lowest priority.
         if (state_q == RESP && bus.rsp_ready) begin
            ptr_q <= id_q;
         end
      end
   end

   assign bus.mul_a       = op_a_q;
   assign bus.mul_b       = op_b_q;
   assign bus.rsp_id      = id_q;
   assign bus.rsp_product = prod_q;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wd_q;
   logic             err_q;

   // Counts WAIT cycles; cleared in LAUNCH so each operation starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == LAUNCH) begin
            wd_q <= '0;
         end else if (state_q == WAIT) begin
            wd_q <= wd_q + 1'b1;
         end
         if (load_rsp) begin
            err_q <= timed_out;
         end
      end
   end

   // A real done in the last allowed cycle still wins over the timeout.
   assign timed_out   = (state_q == WAIT) && !bus.mul_done && (wd_q == CNT_W'(TIMEOUT - 1));
   assign bus.rsp_err = err_q;
`else
   // TIMEOUT only sizes the watchdog; keep it referenced in builds without it.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timed_out      = 1'b0;
   assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;
   import mult_pkg::*;

   localparam int NREQ  = 2;
   localparam int WIDTH = 8;
   localparam int TMO   = 20;
   localparam int IDW   = rr_id_w(NREQ);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int                 id;
      logic [2*WIDTH-1:0] prod;
      logic               err;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;

   // stimulus knobs, written by the main process only
   int   p_req = 0, p_rdy = 100, p_drop = 0, fixed_lat = 0;
   bit   stray_en = 0, no_done = 0;
   // behavioural multiplier state
   bit                 m_run = 0;
   int                 m_cnt = 0;
   logic [2*WIDTH-1:0] m_res = '0;
   bit                 real_done = 0;
   // monitor-owned observations
   logic [NREQ-1:0]    acc = '0;
   int                 m_ptr = NREQ - 1;
   bit                 m_busy = 0;
   bit                 prev_acc = 0, prev_real = 0, prev_hold = 0;
   logic [IDW-1:0]     prev_id = '0;
   logic [2*WIDTH-1:0] prev_prod = '0;
   logic               prev_err = 1'b0;
   int                 rsp_cnt = 0;
   int                 rsp_ids[$];
   logic [2*WIDTH-1:0] last_prod = '0;
   logic [IDW-1:0]     last_id = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: requests, multiplier model, response backpressure.
   task automatic step();
      exp_t e;
      int   pa, pb;
      @(posedge clk);
      #1;
      real_done = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            pa     = $signed(bus.req_a[i*WIDTH +: WIDTH]);
            pb     = $signed(bus.req_b[i*WIDTH +: WIDTH]);
            e.id   = i;
            e.prod = no_done ? '0 : (2*WIDTH)'(pa * pb);
            e.err  = no_done;
            sb.push_back(e);
            bus.req_valid[i] = 1'b0;
         end else if (bus.req_valid[i] && $urandom_range(99) < p_drop) begin
            bus.req_valid[i] = 1'b0;
         end
         if (!bus.req_valid[i] && $urandom_range(99) < p_req) begin
            bus.req_valid[i]             = 1'b1;
            bus.req_a[i*WIDTH +: WIDTH]  = WIDTH'($urandom);
            bus.req_b[i*WIDTH +: WIDTH]  = WIDTH'($urandom);
         end
      end
      if (bus.mul_start) begin
         pa    = $signed(bus.mul_a);
         pb    = $signed(bus.mul_b);
         m_res = (2*WIDTH)'(pa * pb);
         m_cnt = (fixed_lat >= 1) ? fixed_lat - 1 : int'($urandom_range(6));
         m_run = 1'b1;
         bus.mul_done    = stray_en && ($urandom_range(2) == 0);
         bus.mul_product = (2*WIDTH)'($urandom);
      end else if (m_run) begin
         if (no_done) begin
            bus.mul_done = 1'b0;
         end else if (m_cnt == 0) begin
            bus.mul_done    = 1'b1;
            bus.mul_product = m_res;
            m_run           = 1'b0;
            real_done       = 1'b1;
         end else begin
            m_cnt--;
            bus.mul_done = 1'b0;
         end
      end else begin
         bus.mul_done    = stray_en && ($urandom_range(5) == 0);
         bus.mul_product = (2*WIDTH)'($urandom);
      end
      bus.rsp_ready = ($urandom_range(99) < p_rdy);
   endtask

   task automatic wait_rsp(input string name, input int n, input int budget);
      int target;
      target = rsp_cnt + n;
      for (int c = 0; c < budget && rsp_cnt < target; c++) step();
      check(name, rsp_cnt, target);
   endtask

   // Monitor: expected grant from the round-robin rule, latency, hold and scoreboard.
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      int              idx;
      bit              found;
      exp_t            e;
      if (reset) begin
         acc = '0; m_ptr = NREQ - 1; m_busy = 0; sb.delete();
         prev_acc = 0; prev_real = 0; prev_hold = 0;
      end else begin
         exp_rdy = '0;
         found   = 0;
         if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = (m_ptr + k) % NREQ;
               if (!found && bus.req_valid[idx]) begin
                  exp_rdy[idx] = 1'b1;
                  found        = 1;
               end
            end
         end
         check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         check("mul_start_latency", 32'(bus.mul_start), 32'(prev_acc));
         if (prev_real) check("rsp_after_done", 32'(bus.rsp_valid), 32'd1);
         if (prev_hold) begin
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_id", 32'(bus.rsp_id), 32'(prev_id));
            check("hold_product", 32'(bus.rsp_product), 32'(prev_prod));
            check("hold_err", 32'(bus.rsp_err), 32'(prev_err));
         end
         if (sb.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
         acc       = bus.req_valid & bus.req_ready;
         prev_acc  = |acc;
         if (|acc) m_busy = 1;
         prev_real = real_done;
         prev_hold = bus.rsp_valid && !bus.rsp_ready;
         prev_id   = bus.rsp_id;
         prev_prod = bus.rsp_product;
         prev_err  = bus.rsp_err;
         if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_product", 32'(bus.rsp_product), 32'(e.prod));
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            m_ptr     = e.id;
            m_busy    = 0;
            last_prod = bus.rsp_product;
            last_id   = bus.rsp_id;
            rsp_ids.push_back(int'(bus.rsp_id));
            rsp_cnt++;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
      check({tag, "_rsp_product"}, 32'(bus.rsp_product), 32'd0);
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      check({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
      check({tag, "_mul_a"}, 32'(bus.mul_a), 32'd0);
      check({tag, "_mul_b"}, 32'(bus.mul_b), 32'd0);
   endtask

   initial begin
      int n;
      reset           = 1'b1;
      bus.req_valid   = '0;
      bus.req_a       = '0;
      bus.req_b       = '0;
      bus.rsp_ready   = 1'b0;
      bus.mul_done    = 1'b0;
      bus.mul_product = '0;
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = '1;
      #1;
      check_all_zero("reset");
      bus.req_valid = '0;
      reset = 1'b0;

      // single request: 3 * -2
      fixed_lat = 8;
      bus.req_a[0 +: WIDTH] = 8'd3;
      bus.req_b[0 +: WIDTH] = 8'hFE;
      bus.req_valid[0]      = 1'b1;
      wait_rsp("single_done", 1, 60);
      check("single_product", 32'(last_prod), 32'h0000FFFA);
      check("single_id", 32'(last_id), 32'd0);

      // reset while waiting for the multiplier
      fixed_lat = 15;
      bus.req_a[WIDTH +: WIDTH] = 8'h5A;
      bus.req_b[WIDTH +: WIDTH] = 8'hC3;
      bus.req_valid[1]          = 1'b1;
      n = 0;
      while (!bus.mul_start && n < 20) begin step(); n++; end
      check("abort_start_seen", 32'(bus.mul_start), 32'd1);
      repeat (3) step();
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.mul_done  = 1'b0;
      m_run         = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (2) step();
      reset = 1'b0;

      // both requesters always valid: alternate starting from requester 0
      fixed_lat = 0;
      p_req     = 100;
      rsp_ids.delete();
      bus.req_valid = '1;
      wait_rsp("rr_done", 4, 200);
      check("rr_count", 32'(rsp_ids.size()), 32'd4);
      for (int i = 0; i < 4 && i < rsp_ids.size(); i++) check("rr_order", 32'(rsp_ids[i]), 32'(i % 2));

      // randomized traffic with backpressure, drops and stray done pulses
      p_req = 50; p_rdy = 60; p_drop = 10; stray_en = 1;
      repeat (3000) step();
      p_req = 0; p_rdy = 100; p_drop = 0; stray_en = 0;
      repeat (60) step();
      check("drain_empty", 32'(sb.size()), 32'd0);

      // response held off for 5 cycles while the other requester waits
      p_rdy = 0;
      bus.req_a[0 +: WIDTH] = 8'h81;
      bus.req_b[0 +: WIDTH] = 8'h7F;
      bus.req_valid[0]      = 1'b1;
      n = 0;
      while (!bus.rsp_valid && n < 40) begin step(); n++; end
      check("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
      bus.req_valid[1] = 1'b1;
      repeat (5) step();
      p_rdy = 100;
      wait_rsp("bp_done", 2, 60);

`ifdef MULT_ARB_TIMEOUT_EN
      // multiplier never answers
      no_done = 1;
      bus.req_valid[0] = 1'b1;
      n = 0;
      while (!bus.mul_start && n < 20) begin step(); n++; end
      check("tmo_start_seen", 32'(bus.mul_start), 32'd1);
      n = 0;
      while (!bus.rsp_valid && n < 60) begin step(); n++; end
      check("tmo_cycles_in_wait", 32'(n - 1), 32'(TMO));
      wait_rsp("tmo_done", 1, 10);
      no_done = 0;
      m_run   = 1'b0;
`endif

      repeat (5) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one 8-bit Booth multiplier datapath and its FSM among NREQ requesters. Each requester uses a valid/ready handshake. The block grants requesters round-robin, latches the winner's operands, and pulses the multiplier start. It then waits for the multiplier's done, and returns the product, tagged with the requester id, on a single response channel. It sits between client blocks and the multiplier.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 8, operand width in bits; product is 2*WIDTH
TIMEOUT, 20, max cycles waiting for mul_done (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  NREQ*WIDTH  multiplicand, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  multiplier, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NREQ)  requester index of the response
rsp_product  out  2*WIDTH  signed product
rsp_err  out  1  timeout flag; constant 0 without the optional feature
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  WIDTH  operand A to the multiplier
mul_b  out  WIDTH  operand B to the multiplier
mul_done  in  1  multiplier completion, single-cycle pulse
mul_product  in  2*WIDTH  multiplier result, valid when mul_done=1

Behaviour:
- Reset and register initial values:
  - Asynchronous reset: state=IDLE.
  - All outputs 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority after reset.
- State IDLE:
  - If any req_valid: req_ready[w]=1 combinationally for winner w, chosen from the first valid index after the pointer, wrapping.
  - Latch req_a/req_b of w into the operand regs and w into the id reg; go to LAUNCH.
  - req_ready is 0 in every other state.
- State LAUNCH: mul_start=1 for exactly one cycle; go to WAIT.
- State WAIT:
  - On mul_done: latch mul_product; go to RESP.
- Operand stability: mul_a/mul_b are driven from the operand regs and held stable from LAUNCH through WAIT.
- State RESP:
  - rsp_valid=1; rsp_id, rsp_product and rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: pointer=rsp_id; go to IDLE. rsp_valid drops the next cycle.
- No request is accepted while a response is pending. At most one operation is in flight.
- Latency: with the handshake in cycle 0, mul_start is in cycle 1. If mul_done arrives in cycle 1+k, rsp_valid rises in cycle 2+k.
- Minimum request-to-request throughput is 4 cycles plus the multiplier latency.
- Boundary conditions:
  - mul_done in IDLE, LAUNCH or RESP: ignored.
  - mul_done in the same cycle as mul_start: ignored, because the state is LAUNCH.
  - A requester dropping req_valid before grant: legal, no effect.
  - All req_valid low: remain in IDLE, pointer unchanged.
  - Reset in any state: immediate return to IDLE. The in-flight operation is discarded and no response is issued.
- Arithmetic: operands and the product are passed through unmodified. The arbiter performs no sign handling.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter resets on entering WAIT.
  - If TIMEOUT cycles elapse without mul_done: go to RESP with rsp_err=1 and rsp_product=0.
  - A successful completion gives rsp_err=0.
- Without the macro: no counter; WAIT lasts indefinitely; rsp_err tied to 0.

Decomposition:
- Package mult_pkg:
  - arb_state_t enum: IDLE, LAUNCH, WAIT, RESP, 2-bit.
  - Default WIDTH constant.
  - Round-robin id width helper.
- Sub-module mult_rr_picker: combinational. Inputs are req vector and pointer; outputs are grant_valid and grant index. It contains the rotate-and-priority-encode logic.

Test Plan:
- Single request: req0 with a=8'd3, b=8'hFE (-2), multiplier model done after 8 cycles -> mul_start 1 cycle after accept; rsp_product=16'hFFFA, rsp_id=0, rsp_err=0.
- Both requesters always valid: rsp_id sequence 0,1,0,1 over 4 operations; req_ready never asserted for both in one cycle.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_product stable throughout; no req_ready pulse until 1 cycle after the rsp handshake.
- Stray done: mul_done pulsed in IDLE and in LAUNCH -> no state change; the real done 6 cycles later produces exactly one response.
- Reset in WAIT: assert reset 3 cycles after mul_start -> all outputs 0 immediately; the next accept grants req0; no response for the aborted operation.
- With MULT_ARB_TIMEOUT_EN and TIMEOUT=20: mul_done never asserted -> rsp_valid 20 cycles after entering WAIT with rsp_err=1 and rsp_product=0.
